row_permute_engine: RTL and testbench
=====================================

Name: row_permute_engine

Overview:
- Parametrised next-generation row-permutation encryptor/decryptor for the external 16-bit async SRAM.
- Reads one chaotic key word per row from the key table and moves one full image row between the source and destination areas through an internal row buffer.
- Encrypt mode gathers rows: the key selects the source row and destination rows are sequential.
- Decrypt mode scatters rows: source rows are sequential and the key selects the destination row. Start/done handshake with key error reporting.

Parameters:
DATA_W, 16, SRAM data width
ADDR_W, 18, SRAM address width
ROW_LEN, 64, words per row (>=2)
NUM_ROWS, 384, rows per image (<=2^DATA_W-1)
KEY_BASE, 18'hC100, address of key word for row 0
SRC_BASE, 18'h00000, source image base
DST_BASE, 18'hC600, destination image base

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a run when idle
mode  in  1  0=encrypt (gather), 1=decrypt (scatter); sampled on start
databus  inout  DATA_W  SRAM data; driven only while writing, else Z
addressbus  out  ADDR_W  SRAM address
ce  out  1  chip enable, constant 0
lsb  out  1  byte lane enable, constant 0
msb  out  1  byte lane enable, constant 0
oe  out  1  output enable, active low
we  out  1  write enable, active low
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at end of run
key_err  out  1  sticky; set on an invalid key, cleared on next accepted start
led  out  1  high after the first completed run until reset

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; oe=1, we=1, databus=Z; busy=0, done=0, key_err=0, led=0; row counter r=0; word counter w=0; addressbus=KEY_BASE.
- start is accepted only in IDLE. start while busy is ignored.
- On acceptance: latch mode, clear key_err, busy=1, r=0.
- The SRAM read takes two cycles: a cycle with the address valid and oe=0, then a cycle that samples databus and returns oe to 1.
- The SRAM write takes two cycles: a cycle with address and data valid and we=0, then a cycle with we=1 and data still driven.
- Address and data never change while oe=0 or we=0.
- State machine:
  - IDLE -> KEY_RD on accepted start.
  - KEY_RD: addressbus=KEY_BASE+r, oe=0 -> KEY_LAT.
  - KEY_LAT: k=databus, oe=1.
    - Valid key is 1..NUM_ROWS; p=k-1.
    - Invalid key: set key_err and go to NEXT. The row is not copied and the destination row keeps its old contents.
    - Valid key -> ROW_RD with w=0.
  - ROW_RD: addressbus=SRC_BASE+srow*ROW_LEN+w, oe=0 -> ROW_LAT.
    - srow=p when encrypting, srow=r when decrypting.
  - ROW_LAT: buf[w]=databus, oe=1.
    - If w==ROW_LEN-1: w=0, go to WR_LO.
    - Otherwise w++ and go to ROW_RD.
  - WR_LO: addressbus=DST_BASE+drow*ROW_LEN+w, databus=buf[w], we=0 -> WR_HI.
    - drow=r when encrypting, drow=p when decrypting.
  - WR_HI: we=1.
    - If w==ROW_LEN-1 -> NEXT.
    - Otherwise w++ and go to WR_LO.
  - NEXT: if r==NUM_ROWS-1 -> DONE, otherwise r++ and go to KEY_RD.
  - DONE: done=1 for one cycle, busy=0, led=1 -> IDLE.
- Latency for a valid row: 4*ROW_LEN+3 cycles (KEY_RD through NEXT inclusive). A full run with all keys valid takes NUM_ROWS*(4*ROW_LEN+3)+1 cycles from acceptance to the done pulse.
- Row address arithmetic: product computed in ADDR_W bits, wrap-around modulo 2^ADDR_W. No overlap checking between areas.
- Duplicate keys are not detected. In decrypt mode the last write to a destination row wins.
- Reset mid-run aborts immediately: oe and we return to 1 and databus goes Z. SRAM contents are left partially permuted.

Optional Feature:
- Macro PIXEL_XOR_EN.
- When defined, every written word is buf[w] XOR key_lo, where key_lo = k XOR (r mod 2^DATA_W). XOR with the same key is self-inverse, so decrypt with the same key table restores the image.
- When undefined, words are copied unchanged and the run timing is identical.

Test Plan:
- ROW_LEN=4, NUM_ROWS=4, encrypt, keys {3,1,4,2}, src row i words = 16'h0i0w -> dst row0=src row2, row1=row0, row2=row3, row3=row1; done pulses exactly 4*(19)+1=77 cycles after start; led=1.
- Same keys, decrypt applied to the encrypt output -> dst equals the original source image word for word.
- Key table {1,0,5,2} -> key_err=1 after row1. Rows1 and 2 are not written (preloaded 16'hDEAD retained). Rows 0 and 3 are copied correctly and done still pulses.
- Assert reset low during WR_LO of row 2 -> oe=we=1, databus=Z, busy=0, led=0 asynchronously. A later start runs a full pass correctly.
- start pulsed again while busy, and a 2-cycle start pulse -> exactly one run. The bus protocol monitor never sees an address or data change while oe=0 or we=0.
- PIXEL_XOR_EN defined, keys {2,1}, ROW_LEN=2: encrypt then decrypt returns the original data. The encrypted dst row0 word equals src row1 word XOR 16'h0002.

Source files
------------

// File: rtl/row_permute_engine.sv
// row_permute_engine
//   Row-permutation encryptor/decryptor for an external 16-bit async SRAM.
//   Encrypt (mode=0) gathers rows: key selects the source row and destination
//   rows are sequential. Decrypt (mode=1) scatters rows: source rows are
//   sequential and the key selects the destination row.
//   Compile-time option: define PIXEL_XOR_EN to XOR every written word with
//   (key ^ row index); undefined, words are copied unchanged with identical timing.
//
// Handshake: start is a one-cycle request that is honoured only in IDLE and
// ignored otherwise. busy is high from the acceptance edge until the done pulse.
// done is high for exactly one cycle at the end of the run.
//
// SRAM access: every read is two cycles (address with oe=0, then oe=1 with the
// sampled word in use). Every write is two cycles (address and data with we=0,
// then we=1 with data still driven). All bus outputs are registered and change
// only on the edge that opens an access, so they are stable while a strobe is low.
module row_permute_engine #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 18,
    parameter int                 ROW_LEN  = 64,
    parameter int                 NUM_ROWS = 384,
    parameter logic [ADDR_W-1:0]  KEY_BASE = 18'h0C100,
    parameter logic [ADDR_W-1:0]  SRC_BASE = 18'h00000,
    parameter logic [ADDR_W-1:0]  DST_BASE = 18'h0C600
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    inout  wire  [DATA_W-1:0] databus,
    output logic [ADDR_W-1:0] addressbus,
    output logic              ce,
    output logic              lsb,
    output logic              msb,
    output logic              oe,
    output logic              we,
    output logic              busy,
    output logic              done,
    output logic              key_err,
    output logic              led
);

    localparam int W_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [W_W-1:0]    LAST_W  = W_W'(ROW_LEN - 1);
    localparam logic [DATA_W-1:0] LAST_R  = DATA_W'(NUM_ROWS - 1);
    localparam logic [DATA_W-1:0] MAX_KEY = DATA_W'(NUM_ROWS);

    typedef enum logic [3:0] {
        IDLE,
        KEY_RD,
        KEY_LAT,
        ROW_RD,
        ROW_LAT,
        WR_LO,
        WR_HI,
        NEXT,
        DONE
    } state_t;

    // Current FSM state; kept as a plainly named signal so checkers can bind to it.
    state_t state;

    logic              mode_q;    // latched direction for the whole run
    logic [DATA_W-1:0] r;         // row counter
    logic [W_W-1:0]    w;         // word counter within a row
    logic [DATA_W-1:0] p_q;       // key-derived row index (key - 1)
    logic [DATA_W-1:0] rd_q;      // word captured at the end of an oe=0 cycle
    logic [DATA_W-1:0] data_q;    // word being written
    logic              drive;     // databus output enable
    logic [DATA_W-1:0] row_buf [ROW_LEN];
`ifdef PIXEL_XOR_EN
    logic [DATA_W-1:0] key_q;     // raw key of the current row
`endif

    // Key decode from the freshly captured key word.
    logic              key_ok;
    logic [DATA_W-1:0] key_row;
    logic [DATA_W-1:0] srow_first;
    logic [DATA_W-1:0] srow;
    logic [DATA_W-1:0] drow;
    logic [W_W-1:0]    w_inc;

    // Row selection for the current direction and next word index.
    always_comb begin
        key_ok     = (rd_q != '0) && (rd_q <= MAX_KEY);
        key_row    = rd_q - DATA_W'(1);
        srow_first = mode_q ? r : key_row;
        srow       = mode_q ? r : p_q;
        drow       = mode_q ? p_q : r;
        w_inc      = w + W_W'(1);
    end

    // Row/word to SRAM address, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] row_addr(
        input logic [ADDR_W-1:0] base,
        input logic [DATA_W-1:0] row,
        input logic [W_W-1:0]    word
    );
        return base + ADDR_W'(row) * ADDR_W'(ROW_LEN) + ADDR_W'(word);
    endfunction

    // Word that actually goes onto the bus for a buffered pixel.
    function automatic logic [DATA_W-1:0] pix(input logic [DATA_W-1:0] word);
`ifdef PIXEL_XOR_EN
        return word ^ key_q ^ r;
`else
        return word;
`endif
    endfunction

    assign ce      = 1'b0;
    assign lsb     = 1'b0;
    assign msb     = 1'b0;
    assign databus = drive ? data_q : {DATA_W{1'bz}};

    // Capture the SRAM word at the end of every oe=0 cycle.
    always_ff @(posedge clk) begin
        if (!oe) begin
            rd_q <= databus;
        end
    end

    // Fill the row buffer one word per ROW_LAT cycle.
    always_ff @(posedge clk) begin
        if (state == ROW_LAT) begin
            row_buf[w] <= rd_q;
        end
    end

    // Main controller: sequencing, registered bus strobes and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            r          <= '0;
            w          <= '0;
            p_q        <= '0;
            data_q     <= '0;
            drive      <= 1'b0;
            addressbus <= KEY_BASE;
            oe         <= 1'b1;
            we         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            key_err    <= 1'b0;
            led        <= 1'b0;
`ifdef PIXEL_XOR_EN
            key_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q     <= mode;
                        key_err    <= 1'b0;
                        busy       <= 1'b1;
                        r          <= '0;
                        w          <= '0;
                        addressbus <= KEY_BASE;
                        oe         <= 1'b0;
                        state      <= KEY_RD;
                    end
                end

                KEY_RD: begin
                    oe    <= 1'b1;
                    state <= KEY_LAT;
                end

                KEY_LAT: begin
                    p_q <= key_row;
`ifdef PIXEL_XOR_EN
                    key_q <= rd_q;
`endif
                    if (key_ok) begin
                        w          <= '0;
                        addressbus <= row_addr(SRC_BASE, srow_first, '0);
                        oe         <= 1'b0;
                        state      <= ROW_RD;
                    end else begin
                        // Row skipped: destination keeps its previous contents.
                        key_err <= 1'b1;
                        state   <= NEXT;
                    end
                end

                ROW_RD: begin
                    oe    <= 1'b1;
                    state <= ROW_LAT;
                end

                ROW_LAT: begin
                    if (w == LAST_W) begin
                        // buf[0] was filled long ago, so the first write can start now.
                        w          <= '0;
                        addressbus <= row_addr(DST_BASE, drow, '0);
                        data_q     <= pix(row_buf[0]);
                        drive      <= 1'b1;
                        we         <= 1'b0;
                        state      <= WR_LO;
                    end else begin
                        w          <= w_inc;
                        addressbus <= row_addr(SRC_BASE, srow, w_inc);
                        oe         <= 1'b0;
                        state      <= ROW_RD;
                    end
                end

                WR_LO: begin
                    we    <= 1'b1;
                    state <= WR_HI;
                end

                WR_HI: begin
                    if (w == LAST_W) begin
                        drive <= 1'b0;
                        state <= NEXT;
                    end else begin
                        w          <= w_inc;
                        addressbus <= row_addr(DST_BASE, drow, w_inc);
                        data_q     <= pix(row_buf[w_inc]);
                        we         <= 1'b0;
                        state      <= WR_LO;
                    end
                end

                NEXT: begin
                    if (r == LAST_R) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        led   <= 1'b1;
                        state <= DONE;
                    end else begin
                        r          <= r + DATA_W'(1);
                        addressbus <= KEY_BASE + ADDR_W'(r + DATA_W'(1));
                        oe         <= 1'b0;
                        state      <= KEY_RD;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_permute_engine.sv
// Testbench for row_permute_engine with a small geometry (4 rows of 4 words).
// An SRAM model serves reads and captures writes; a reference model derives the
// ordered write stream, final destination image and run timing from the key table.
module tb_row_permute_engine;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 18;
    localparam int ROW_LEN  = 4;
    localparam int NUM_ROWS = 4;
    localparam int IMG      = ROW_LEN * NUM_ROWS;
    localparam logic [ADDR_W-1:0] KEY_BASE = 18'h0C100;
    localparam logic [ADDR_W-1:0] SRC_BASE = 18'h00000;
    localparam logic [ADDR_W-1:0] DST_BASE = 18'h0C600;
    localparam logic [DATA_W-1:0] PROBE    = 16'hA5C3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    wire  [DATA_W-1:0] databus;
    logic [ADDR_W-1:0] addressbus;
    logic ce, lsb, msb, oe, we, busy, done, key_err, led;

    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] mem_rd;
    logic              probe_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_dst [IMG];
    logic [DATA_W-1:0] orig [IMG];
    int exp_cycles;
    int exp_err_cyc;
    bit exp_kerr;

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

    row_permute_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_LEN(ROW_LEN), .NUM_ROWS(NUM_ROWS),
        .KEY_BASE(KEY_BASE), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .databus(databus), .addressbus(addressbus),
        .ce(ce), .lsb(lsb), .msb(msb), .oe(oe), .we(we),
        .busy(busy), .done(done), .key_err(key_err), .led(led)
    );

    function automatic logic [DATA_W-1:0] mem_get(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    // SRAM read path: drives the bus while oe is low; the probe lets the bench
    // see whether the DUT has released the bus.
    always @(addressbus or oe) mem_rd = mem_get(addressbus);
    assign databus = (oe == 1'b0) ? mem_rd : (probe_en ? PROBE : {DATA_W{1'bz}});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor: SRAM writes ----------------
    always @(posedge clk) begin
        if (reset && done) done_cnt++;
        if (reset && we == 1'b0) begin
            mem[addressbus] = databus;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", addressbus, databus);
            end else begin
                check("write", {addressbus, databus}, exp_q.pop_front());
            end
        end
    end

    // ---------------- bus protocol monitor ----------------
    logic p_oe = 1'b1, p_we = 1'b1, p_rst = 1'b0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [DATA_W-1:0] p_data = '0;
    always @(negedge clk) begin
        if (reset && p_rst) begin
            if (p_oe == 1'b0) begin
                check("oe_width", oe, 1);
                check("rd_addr_hold", addressbus, p_addr);
            end
            if (p_we == 1'b0) begin
                check("we_width", we, 1);
                check("wr_addr_hold", addressbus, p_addr);
                check("wr_data_hold", databus, p_data);
            end
        end
        p_oe = oe; p_we = we; p_rst = reset; p_addr = addressbus; p_data = databus;
    end

    // ---------------- reference model ----------------
    task automatic model_run(input bit m);
        int t;
        t = 0;
        exp_err_cyc = 0;
        exp_kerr = 0;
        for (int i = 0; i < IMG; i++) exp_dst[i] = mem_get(DST_BASE + ADDR_W'(i));
        for (int r = 0; r < NUM_ROWS; r++) begin
            int k, srow, drow;
            logic [DATA_W-1:0] word;
            k = int'(mem_get(KEY_BASE + ADDR_W'(r)));
            if (k < 1 || k > NUM_ROWS) begin
                t += 3;
                if (!exp_kerr) exp_err_cyc = t;
                exp_kerr = 1;
            end else begin
                srow = m ? r : k - 1;
                drow = m ? k - 1 : r;
                for (int w = 0; w < ROW_LEN; w++) begin
                    word = mem_get(SRC_BASE + ADDR_W'(srow * ROW_LEN + w));
`ifdef PIXEL_XOR_EN
                    word = word ^ DATA_W'(k) ^ DATA_W'(r);
`endif
                    exp_q.push_back({DST_BASE + ADDR_W'(drow * ROW_LEN + w), word});
                    exp_dst[drow * ROW_LEN + w] = word;
                end
                t += 4 * ROW_LEN + 3;
            end
        end
        exp_cycles = t + 1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_keys(input int k0, input int k1, input int k2, input int k3);
        mem[KEY_BASE + 0] = DATA_W'(k0);
        mem[KEY_BASE + 1] = DATA_W'(k1);
        mem[KEY_BASE + 2] = DATA_W'(k2);
        mem[KEY_BASE + 3] = DATA_W'(k3);
    endtask

    task automatic fill_dst(input logic [DATA_W-1:0] v);
        for (int i = 0; i < IMG; i++) mem[DST_BASE + ADDR_W'(i)] = v;
    endtask

    // One full run; dbl holds start for two cycles, poke re-pulses it mid-run.
    task automatic run(input bit m, input bit dbl, input bit poke, input string tag, output int cyc);
        int err_seen, d0;
        model_run(m);
        d0 = done_cnt;
        err_seen = 0;
        cyc = 0;
        @(negedge clk);
        mode = m;
        start = 1'b1;
        while (1) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) begin
                check({tag, "_busy_on"}, busy, 1);
                check({tag, "_kerr_clear"}, key_err, 0);
                if (!dbl) start = 1'b0;
                mode = ~m;
            end
            if (cyc == 2) start = 1'b0;
            if (poke && cyc == 30) start = 1'b1;
            if (poke && cyc == 31) start = 1'b0;
            if (key_err && err_seen == 0) err_seen = cyc;
            if (done || cyc >= 5000) break;
        end
        check({tag, "_cycles"}, cyc, exp_cycles);
        check({tag, "_key_err"}, key_err, exp_kerr);
        check({tag, "_key_err_cycle"}, err_seen, exp_kerr ? exp_err_cyc : 0);
        check({tag, "_busy_off"}, busy, 0);
        check({tag, "_led"}, led, 1);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, done, 0);
        repeat (40) @(posedge clk);
        #1;
        check({tag, "_idle_after"}, busy, 0);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_writes_left"}, exp_q.size(), 0);
        for (int i = 0; i < IMG; i++)
            check({tag, "_dst"}, mem_get(DST_BASE + ADDR_W'(i)), exp_dst[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, base, guard;

        // Reset state
        #23;
        probe_en = 1'b1;
        #1;
        check("rst_oe", oe, 1);
        check("rst_we", we, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_key_err", key_err, 0);
        check("rst_led", led, 0);
        check("rst_addr", addressbus, KEY_BASE);
        check("rst_ce_lanes", {ce, lsb, msb}, 0);
        check("rst_bus_released", databus, PROBE);
        probe_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Encrypt with keys {3,1,4,2}
        for (int i = 0; i < NUM_ROWS; i++)
            for (int w = 0; w < ROW_LEN; w++) begin
                orig[i * ROW_LEN + w] = DATA_W'((i << 8) | w);
                mem[SRC_BASE + ADDR_W'(i * ROW_LEN + w)] = orig[i * ROW_LEN + w];
            end
        load_keys(3, 1, 4, 2);
        fill_dst('0);
        run(0, 0, 0, "enc", cyc);
        check("enc_cycles_77", cyc, 77);

        // Decrypt the encrypted image back
        for (int i = 0; i < IMG; i++) mem[SRC_BASE + ADDR_W'(i)] = mem_get(DST_BASE + ADDR_W'(i));
        fill_dst('0);
        run(1, 0, 0, "dec", cyc);
        for (int i = 0; i < IMG; i++)
            check("dec_roundtrip", mem_get(DST_BASE + ADDR_W'(i)), orig[i]);

        // Invalid keys {1,0,5,2}
        for (int i = 0; i < IMG; i++) mem[SRC_BASE + ADDR_W'(i)] = orig[i];
        fill_dst(16'hDEAD);
        load_keys(1, 0, 5, 2);
        run(0, 0, 0, "kerr", cyc);
        for (int w = 0; w < ROW_LEN; w++) begin
            check("kerr_row1_kept", mem_get(DST_BASE + ADDR_W'(1 * ROW_LEN + w)), 16'hDEAD);
            check("kerr_row2_kept", mem_get(DST_BASE + ADDR_W'(2 * ROW_LEN + w)), 16'hDEAD);
        end

        // Reset during WR_LO of row 2
        load_keys(3, 1, 4, 2);
        model_run(0);
        base = wr_cnt;
        guard = 0;
        @(negedge clk);
        mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!((wr_cnt - base) >= 2 * ROW_LEN && we == 1'b0) && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("mid_reached_row2_wr", ((wr_cnt - base) >= 2 * ROW_LEN && we == 1'b0), 1);
        #2;
        reset = 1'b0;
        probe_en = 1'b1;
        #1;
        check("mid_oe", oe, 1);
        check("mid_we", we, 1);
        check("mid_busy", busy, 0);
        check("mid_led", led, 0);
        check("mid_bus_released", databus, PROBE);
        exp_q.delete();
        probe_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        fill_dst('0);
        run(0, 0, 0, "post_rst", cyc);

        // Two-cycle start pulse plus a start while busy
        fill_dst(16'h1234);
        run(1, 1, 1, "busy_start", cyc);

        // Randomised runs
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < IMG; i++) mem[SRC_BASE + ADDR_W'(i)] = DATA_W'($urandom);
            for (int r = 0; r < NUM_ROWS; r++)
                mem[KEY_BASE + ADDR_W'(r)] = DATA_W'($urandom_range(0, NUM_ROWS + 1));
            run(1'($urandom_range(0, 1)), 0, 0, "rand", cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
